// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: a circular FIFO of
// {instruction, cur_pc, incremented_pc} triples with a valid/ready output
// handshake, a fetch stall when full and a whole-queue flush on redirect.
module fetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_W     = $clog2(DEPTH) + 1,
    parameter int unsigned INSTR_LEN = 32,
    parameter int unsigned WORD      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [INSTR_LEN-1:0] in_instruction,
    input  logic [WORD-1:0]      in_cur_pc,
    input  logic [WORD-1:0]      in_incremented_pc,
    output logic                 in_ready,
    output logic                 stall_fetch,
    output logic                 out_valid,
    output logic [INSTR_LEN-1:0] out_instruction,
    output logic [WORD-1:0]      out_cur_pc,
    output logic [WORD-1:0]      out_incremented_pc,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [INSTR_LEN-1:0] instr_q [DEPTH];
    logic [INSTR_LEN-1:0] instr_d [DEPTH];
    logic [WORD-1:0]      pc_q    [DEPTH];
    logic [WORD-1:0]      pc_d    [DEPTH];
    logic [WORD-1:0]      ipc_q   [DEPTH];
    logic [WORD-1:0]      ipc_d   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic push, pop;

    // Handshake status depends only on registered occupancy; a same-cycle
    // pop never makes room for a push (no pass-through when full).
    always_comb begin
        in_ready    = (count_q != FULL_CNT);
        stall_fetch = ~in_ready;
        out_valid   = (count_q != '0);
        count       = count_q;
        push        = in_valid && in_ready;
        pop         = out_valid && out_ready;
    end

    // Head entry is presented directly from storage, zeroed when empty.
    always_comb begin
        out_instruction    = '0;
        out_cur_pc         = '0;
        out_incremented_pc = '0;
        if (out_valid) begin
            out_instruction    = instr_q[rd_ptr_q];
            out_cur_pc         = pc_q[rd_ptr_q];
            out_incremented_pc = ipc_q[rd_ptr_q];
        end
    end

    // Next-state for pointers and occupancy; flush behaves like reset.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage write of the incoming triple at the write pointer.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        ipc_d   = ipc_q;
        if (push && !flush) begin
            instr_d[wr_ptr_q] = in_instruction;
            pc_d[wr_ptr_q]    = in_cur_pc;
            ipc_d[wr_ptr_q]   = in_incremented_pc;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless while empty, so no reset.
    always_ff @(posedge clk) begin
        instr_q <= instr_d;
        pc_q    <= pc_d;
        ipc_q   <= ipc_d;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a queue-based scoreboard of expected
// head entries, plus explicit checks at the interesting points.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] ipc;
    } ent_t;

    logic             clk = 1'b0;
    logic             reset, flush, in_valid, out_ready;
    logic [31:0]      in_instruction, in_cur_pc, in_incremented_pc;
    logic             in_ready, stall_fetch, out_valid;
    logic [31:0]      out_instruction, out_cur_pc, out_incremented_pc;
    logic [CNT_W-1:0] count;

    int   n_tests = 0;
    int   n_fail  = 0;
    ent_t sb[$];

    fetch_queue #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_instruction    (in_instruction),
        .in_cur_pc         (in_cur_pc),
        .in_incremented_pc (in_incremented_pc),
        .in_ready          (in_ready),
        .stall_fetch       (stall_fetch),
        .out_valid         (out_valid),
        .out_instruction   (out_instruction),
        .out_cur_pc        (out_cur_pc),
        .out_incremented_pc(out_incremented_pc),
        .out_ready         (out_ready),
        .count             (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare all outputs against the scoreboard's view of the queue.
    task automatic check_outputs(input string tag);
        ent_t head;
        head = (sb.size() != 0) ? sb[0] : '0;
        chk({tag, "_count"}, 32'(count), 32'(sb.size()));
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(sb.size() != 0));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(sb.size() != DEPTH));
        chk({tag, "_stall"}, 32'(stall_fetch), 32'(sb.size() == DEPTH));
        chk({tag, "_instr"}, out_instruction, head.instr);
        chk({tag, "_pc"}, out_cur_pc, head.pc);
        chk({tag, "_ipc"}, out_incremented_pc, head.ipc);
    endtask

    // One clock cycle: drive, check before the edge, update the model.
    task automatic step(input string tag, input logic rst, input logic fl, input logic iv,
                        input logic [31:0] ins, input logic [31:0] pc, input logic ordy);
        bit do_push, do_pop;
        reset             = rst;
        flush             = fl;
        in_valid          = iv;
        in_instruction    = ins;
        in_cur_pc         = pc;
        in_incremented_pc = pc + 32'd4;
        out_ready         = ordy;
        @(negedge clk);
        check_outputs(tag);
        if (rst || fl) begin
            sb.delete();
        end else begin
            do_push = iv && (sb.size() != DEPTH);
            do_pop  = ordy && (sb.size() != 0);
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back('{instr: ins, pc: pc, ipc: pc + 32'd4});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instruction = '0; in_cur_pc = '0; in_incremented_pc = '0;
        @(posedge clk);
        #1;

        // 1: reset, then a single push
        step("t1_rst", 1, 0, 0, 32'h0, 32'd0, 0);
        chk("t1_rst_count", 32'(count), 32'd0);
        chk("t1_rst_in_ready", 32'(in_ready), 32'd1);
        step("t1_push", 0, 0, 1, 32'hABCDEF12, 32'd0, 0);
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_instr", out_instruction, 32'hABCDEF12);
        chk("t1_pc", out_cur_pc, 32'd0);
        chk("t1_ipc", out_incremented_pc, 32'd4);
        chk("t1_count", 32'(count), 32'd1);

        // 2: fill with decode stalled, then a rejected fifth push
        step("t2_p1", 0, 0, 1, 32'hBCDEF123, 32'd4, 0);
        step("t2_p2", 0, 0, 1, 32'hCDEF1234, 32'd8, 0);
        step("t2_p3", 0, 0, 1, 32'hDEF12345, 32'd12, 0);
        chk("t2_full_count", 32'(count), 32'd4);
        chk("t2_full_in_ready", 32'(in_ready), 32'd0);
        chk("t2_full_stall", 32'(stall_fetch), 32'd1);
        chk("t2_full_head", out_instruction, 32'hABCDEF12);
        step("t2_p5", 0, 0, 1, 32'hEF123456, 32'd16, 0);
        chk("t2_p5_count", 32'(count), 32'd4);
        chk("t2_p5_head_pc", out_cur_pc, 32'd0);

        // 3: push+pop at count 2, then wrap through 8 cycles
        step("t3_rst", 1, 0, 0, 32'h0, 32'd0, 0);
        step("t3_a", 0, 0, 1, 32'hABCDEF12, 32'd0, 0);
        step("t3_b", 0, 0, 1, 32'hBCDEF123, 32'd4, 0);
        for (int i = 0; i < 8; i++) begin
            step("t3_pp", 0, 0, 1, 32'h1000_0000 + 32'(i), 32'd8 + 32'(4 * i), 1);
            if (i == 0) begin
                chk("t3_pp_count", 32'(count), 32'd2);
                chk("t3_pp_head_pc", out_cur_pc, 32'd4);
                chk("t3_pp_head_instr", out_instruction, 32'hBCDEF123);
            end
        end

        // 4: flush with a concurrent push, then the branch target
        step("t4_fill", 0, 0, 1, 32'h2222_0000, 32'd200, 0);
        chk("t4_pre_count", 32'(count), 32'd3);
        step("t4_flush", 0, 1, 1, 32'h6789ABCD, 32'd44, 0);
        chk("t4_flush_count", 32'(count), 32'd0);
        chk("t4_flush_valid", 32'(out_valid), 32'd0);
        step("t4_target", 0, 0, 1, 32'h6789ABCD, 32'd44, 0);
        chk("t4_target_pc", out_cur_pc, 32'd44);
        chk("t4_target_ipc", out_incremented_pc, 32'd48);

        // 5: reset mid-operation with consumer ready
        step("t5_f1", 0, 0, 1, 32'h3333_0001, 32'd60, 0);
        step("t5_f2", 0, 0, 1, 32'h3333_0002, 32'd64, 0);
        chk("t5_pre_count", 32'(count), 32'd3);
        step("t5_rst", 1, 0, 1, 32'h3333_0003, 32'd68, 1);
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_instr", out_instruction, 32'd0);
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        step("t5_push", 0, 0, 1, 32'h11112222, 32'd100, 0);
        chk("t5_first_pc", out_cur_pc, 32'd100);
        step("t5_drain", 0, 0, 0, 32'h0, 32'd0, 1);

        // 6: fill then drain a full queue
        for (int i = 0; i < 4; i++) begin
            step("t6_fill", 0, 0, 1, 32'h4444_0000 + 32'(i), 32'(4 * i), 0);
        end
        for (int i = 0; i < 4; i++) begin
            chk("t6_drain_pc", out_cur_pc, 32'(4 * i));
            step("t6_drain", 0, 0, 0, 32'h0, 32'd0, 1);
            chk("t6_drain_count", 32'(count), 32'(3 - i));
            chk("t6_drain_in_ready", 32'(in_ready), 32'd1);
        end
        chk("t6_empty_valid", 32'(out_valid), 32'd0);
        chk("t6_empty_pc", out_cur_pc, 32'd0);
        chk("t6_empty_ipc", out_incremented_pc, 32'd0);
        step("t6_idle", 0, 0, 0, 32'h0, 32'd0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer between the iFetch stage and the decode stage.
- Captures each fetched {instruction, cur_pc, incremented_pc} triple into a small circular FIFO and presents the oldest entry to decode through a valid/ready handshake.
- Raises a stall to iFetch when full so the PC holds.
- Discards all buffered entries when a taken branch (pc_src) redirects fetch.

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  driven by pc_src; discards all buffered entries.
- in_valid  input  1  fetch presents a valid triple this cycle.
- in_instruction  input  `INSTR_LEN  fetched instruction.
- in_cur_pc  input  `WORD  PC of in_instruction.
- in_incremented_pc  input  `WORD  in_cur_pc+4.
- in_ready  output  1  queue can accept this cycle.
- stall_fetch  output  1  instructs iFetch to hold the PC.
- out_valid  output  1  head entry is valid.
- out_instruction  output  `INSTR_LEN  head instruction.
- out_cur_pc  output  `WORD  head PC.
- out_incremented_pc  output  `WORD  head PC+4.
- out_ready  input  1  decode consumes the head this cycle.
- count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- State: storage array of DEPTH entries, wr_ptr and rd_ptr ($clog2(DEPTH) bits each, wrap modulo DEPTH), count register.
- Reset (priority 1):
  - wr_ptr, rd_ptr and count all clear to 0.
  - All outputs are in their empty state: out_valid=0; out_* data=0; in_ready=1; stall_fetch=0; count=0.
  - Storage contents are don't-care.
- Flush (priority 2, when reset=0): same effect as reset on pointers and count.
  - A push or pop requested in the same cycle is ignored.
  - The cycle after a flush the queue is empty.
  - The first post-flush push (the branch-target instruction) is accepted the following cycle.
- Push: occurs when in_valid && in_ready.
  - Writes the triple at wr_ptr.
  - wr_ptr advances by 1 with wrap.
- Pop: occurs when out_valid && out_ready.
  - rd_ptr advances by 1 with wrap.
- Count:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, both pointers advance.
- in_ready = (count != DEPTH). It is combinational from registered count only. A pop in the same cycle does NOT free a slot; there is no pass-through when full.
- stall_fetch = ~in_ready.
- out_valid = (count != 0).
- out_* data:
  - Combinational read of storage[rd_ptr] when out_valid=1.
  - Forced to 0 when out_valid=0.
  - There is no bypass: an entry pushed at edge N is visible at out_* after edge N, so minimum latency is 1 cycle.
- Empty with in_valid=1 and out_ready=1: push only. out_valid is 0 that cycle.
- Full with out_ready=1: pop only. in_ready is 1 the next cycle.
- in_valid=0 or out_ready=0 never alter pointers or count.
- Outputs may be held by the consumer indefinitely. out_* must stay stable while out_valid=1 and out_ready=0.
- Count never exceeds DEPTH and never underflows. The handshake gates make overflow and underflow unreachable.

Test Plan:
1. Reset, then push single entry:
   - Stimulus: hold reset=1 for one cycle; release; push {ABCDEF12, 0, 4}.
   - Required: during reset, count=0, out_valid=0, in_ready=1.
   - Required: next cycle, out_valid=1, out_instruction=ABCDEF12, out_cur_pc=0, out_incremented_pc=4, count=1.
2. Fill with decode stalled:
   - Stimulus: push ABCDEF12@0, BCDEF123@4, CDEF1234@8, DEF12345@12 with out_ready=0; then present a fifth push.
   - Required: after the 4th push, count=4, in_ready=0, stall_fetch=1, head still ABCDEF12@0.
   - Required: the 5th push (in_valid=1) is not accepted and count stays 4.
3. Simultaneous push and pop at count=2:
   - Required: count stays 2.
   - Required: head advances from ABCDEF12@0 to BCDEF123@4.
   - Required: wrap-around is exercised by running 8 consecutive push+pop cycles; PCs emerge in order 0, 4, 8, ..., 28.
4. Flush on branch:
   - Stimulus: with count=3, assert flush=1 together with in_valid=1 ({6789ABCD, 44, 48}).
   - Required: next cycle, count=0, out_valid=0; the 6789ABCD entry is dropped.
   - Stimulus: push 6789ABCD@44 again the following cycle.
   - Required: out_cur_pc=44, out_incremented_pc=48.
5. Reset mid-operation:
   - Stimulus: with count=3 and out_ready=1, assert reset.
   - Required: next cycle, count=0, out_valid=0, out_* data=0, in_ready=1.
   - Required: the first push after reset emerges first.
6. Drain full queue:
   - Stimulus: full queue, out_ready=1 for 4 cycles, in_valid=0.
   - Required: PCs 0, 4, 8, 12 appear in order, count decrements 4→0.
   - Required: in_ready=1 from the cycle after the first pop.
   - Required: after the last pop, out_valid=0 and out_* data=0.
